// File: rtl/buf2_access_sequencer_if.sv
// Bus bundle between buf2_access_sequencer and its clients: camera writer, edge engine,
// VGA reader and the frame buffer 2 RAM.
interface buf2_access_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              req_capture_i;
  logic              req_filter_i;
  logic              cam_vsync_i;
  logic              cam_we_i;
  logic [ADDR_W-1:0] cam_addr_i;
  logic [DATA_W-1:0] cam_data_i;
  logic              filt_rst_o;
  logic              filt_en_o;
  logic              filt_done_i;
  logic [ADDR_W-1:0] filt_rdaddr_i;
  logic [DATA_W-1:0] filt_rddata_o;
  logic              filt_we_i;
  logic [ADDR_W-1:0] filt_wraddr_i;
  logic [DATA_W-1:0] filt_wrdata_i;
  logic [ADDR_W-1:0] vga_rdaddr_i;
  logic [DATA_W-1:0] vga_rddata_o;
  logic [ADDR_W-1:0] buf_rdaddr_o;
  logic [DATA_W-1:0] buf_rddata_i;
  logic              buf_we_o;
  logic [ADDR_W-1:0] buf_wraddr_o;
  logic [DATA_W-1:0] buf_wrdata_o;
  logic              busy_o;
  logic [1:0]        mode_o;
  logic              done_o;

  modport slave (
    input  req_capture_i, req_filter_i, cam_vsync_i, cam_we_i, cam_addr_i, cam_data_i,
           filt_done_i, filt_rdaddr_i, filt_we_i, filt_wraddr_i, filt_wrdata_i,
           vga_rdaddr_i, buf_rddata_i,
    output filt_rst_o, filt_en_o, filt_rddata_o, vga_rddata_o, buf_rdaddr_o,
           buf_we_o, buf_wraddr_o, buf_wrdata_o, busy_o, mode_o, done_o
  );

  modport master (
    output req_capture_i, req_filter_i, cam_vsync_i, cam_we_i, cam_addr_i, cam_data_i,
           filt_done_i, filt_rdaddr_i, filt_we_i, filt_wraddr_i, filt_wrdata_i,
           vga_rdaddr_i, buf_rddata_i,
    input  filt_rst_o, filt_en_o, filt_rddata_o, vga_rddata_o, buf_rdaddr_o,
           buf_we_o, buf_wraddr_o, buf_wrdata_o, busy_o, mode_o, done_o
  );
endinterface

// File: rtl/buf2_access_sequencer.sv
// Frame buffer 2 owner: sequences DISPLAY/CAPTURE/FILTER and muxes the RAM ports.
// Optional filter watchdog and FAULT state enabled by defining BUF2_WDT_EN.
//
// state     | meaning
// DISPLAY   | VGA owns reads, no writes, accepts requests
// CAP_WAIT  | waiting for first vsync rise
// CAP_RUN   | camera owns writes until next vsync rise
// FILT_ARM  | engine out of reset, not yet enabled
// FILT_RUN  | engine enabled, owns reads and writes
// FILT_END  | engine back in reset, done pulse
// FAULT     | watchdog expired, waiting for any request
module buf2_access_sequencer #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int WDT_CYCLES = 400000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  buf2_access_sequencer_if.slave bus
);

  if (WDT_CYCLES < 1 || WDT_CYCLES > 524288) begin : g_wdt_range_bad
    $error("WDT_CYCLES does not fit the 19-bit watchdog counter");
  end

  typedef enum logic [2:0] {
    S_DISPLAY  = 3'd0,
    S_CAP_WAIT = 3'd1,
    S_CAP_RUN  = 3'd2,
    S_FILT_ARM = 3'd3,
    S_FILT_RUN = 3'd4,
`ifdef BUF2_WDT_EN
    S_FAULT    = 3'd6,
`endif
    S_FILT_END = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_vsync_q, w_vsync_rise;
  logic              r_pend_cap, r_pend_filt, w_pend_cap_nxt, w_pend_filt_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic              r_busy, r_filt_rst, r_filt_en, r_rd_filt;
  logic              w_filt_rd, w_wdt_tc;
  logic              w_we;
  logic [ADDR_W-1:0] w_rdaddr, w_wraddr;
  logic [DATA_W-1:0] w_wrdata;

  assign w_vsync_rise = bus.cam_vsync_i & ~r_vsync_q;
  assign w_filt_rd    = (r_state == S_FILT_ARM) || (r_state == S_FILT_RUN);

`ifdef BUF2_WDT_EN
  logic [18:0] r_wdt_cnt;
  assign w_wdt_tc = (r_wdt_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_wdt_cnt <= '0;
    else if (r_state == S_FILT_ARM)
      r_wdt_cnt <= 19'(WDT_CYCLES - 1);
    else if (r_state == S_FILT_RUN && !w_wdt_tc)
      r_wdt_cnt <= r_wdt_cnt - 19'd1;
  end
`else
  assign w_wdt_tc = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_DISPLAY;
      r_vsync_q   <= 1'b0;
      r_pend_cap  <= 1'b0;
      r_pend_filt <= 1'b0;
      r_mode      <= 2'b00;
      r_busy      <= 1'b0;
      r_filt_rst  <= 1'b1;
      r_filt_en   <= 1'b0;
      r_rd_filt   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vsync_q   <= bus.cam_vsync_i;
      r_pend_cap  <= w_pend_cap_nxt;
      r_pend_filt <= w_pend_filt_nxt;
      r_mode      <= w_mode_nxt;
      r_busy      <= (w_state_nxt != S_DISPLAY);
      r_filt_rst  <= !((w_state_nxt == S_FILT_ARM) || (w_state_nxt == S_FILT_RUN));
      r_filt_en   <= (w_state_nxt == S_FILT_RUN);
      r_rd_filt   <= w_filt_rd;
    end
  end

  // Pending filter goes out on the DISPLAY cycle's edge, so DISPLAY shows for exactly one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_pend_cap_nxt  = r_pend_cap;
    w_pend_filt_nxt = r_pend_filt;
    if (r_state != S_DISPLAY) begin
      if (bus.req_capture_i) w_pend_cap_nxt = 1'b1;
      if (bus.req_filter_i)  w_pend_filt_nxt = 1'b1;
    end
    case (r_state)
      S_DISPLAY: begin
        if (bus.req_capture_i || r_pend_cap) begin
          w_state_nxt    = S_CAP_WAIT;
          w_pend_cap_nxt = 1'b0;
          if (bus.req_filter_i) w_pend_filt_nxt = 1'b1;
        end else if (bus.req_filter_i || r_pend_filt) begin
          w_state_nxt     = S_FILT_ARM;
          w_pend_filt_nxt = 1'b0;
        end
      end
      S_CAP_WAIT: if (w_vsync_rise) w_state_nxt = S_CAP_RUN;
      S_CAP_RUN:  if (w_vsync_rise) w_state_nxt = S_DISPLAY;
      S_FILT_ARM: w_state_nxt = S_FILT_RUN;
      S_FILT_RUN: begin
        if (bus.filt_done_i) w_state_nxt = S_FILT_END;
`ifdef BUF2_WDT_EN
        else if (w_wdt_tc)   w_state_nxt = S_FAULT;
`endif
      end
      S_FILT_END: w_state_nxt = S_DISPLAY;
`ifdef BUF2_WDT_EN
      S_FAULT: begin
        if (bus.req_capture_i || bus.req_filter_i) begin
          w_state_nxt     = S_DISPLAY;
          w_pend_cap_nxt  = 1'b0;
          w_pend_filt_nxt = 1'b0;
        end
      end
`endif
      default: w_state_nxt = S_DISPLAY;
    endcase

    w_mode_nxt = 2'b00;
    case (w_state_nxt)
      S_CAP_WAIT, S_CAP_RUN:             w_mode_nxt = 2'b01;
      S_FILT_ARM, S_FILT_RUN, S_FILT_END: w_mode_nxt = 2'b10;
`ifdef BUF2_WDT_EN
      S_FAULT:                           w_mode_nxt = 2'b11;
`endif
      default:                           w_mode_nxt = 2'b00;
    endcase
  end

  always_comb begin
    w_we     = 1'b0;
    w_wraddr = '0;
    w_wrdata = '0;
    if (r_state == S_CAP_RUN) begin
      w_we     = bus.cam_we_i;
      w_wraddr = bus.cam_addr_i;
      w_wrdata = bus.cam_data_i;
    end else if (r_state == S_FILT_RUN) begin
      w_we     = bus.filt_we_i;
      w_wraddr = bus.filt_wraddr_i;
      w_wrdata = bus.filt_wrdata_i;
    end
  end

  assign w_rdaddr = w_filt_rd ? bus.filt_rdaddr_i : bus.vga_rdaddr_i;

  assign bus.buf_rdaddr_o  = w_rdaddr;
  assign bus.buf_we_o      = w_we;
  assign bus.buf_wraddr_o  = w_wraddr;
  assign bus.buf_wrdata_o  = w_wrdata;
  assign bus.filt_rddata_o = bus.buf_rddata_i;
  assign bus.vga_rddata_o  = r_rd_filt ? '0 : bus.buf_rddata_i;
  assign bus.filt_rst_o    = r_filt_rst;
  assign bus.filt_en_o     = r_filt_en;
  assign bus.busy_o        = r_busy;
  assign bus.mode_o        = r_mode;
  assign bus.done_o        = ((r_state == S_CAP_RUN) && w_vsync_rise) || (r_state == S_FILT_END);

endmodule
